// File: rtl/irq_controller_pkg.sv
// Shared definitions for the vectored interrupt controller.
//   - register offsets on the 8-bit IO bus
//   - FSM state encodings
//   - id/vector widths and the latched request payload
package irq_controller_pkg;

   localparam int unsigned IRQ_ID_W = 3;
   localparam int unsigned REG_W    = 8;
   localparam int unsigned VEC_W    = 16;
   localparam int unsigned ADDR_W   = 2;

   typedef enum logic [ADDR_W-1:0] {
      REG_ENABLE    = 2'd0,
      REG_PENDING   = 2'd1,
      REG_MODE      = 2'd2,
      REG_INSERVICE = 2'd3
   } reg_addr_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   // Request presented to the control unit, held stable while irq_req=1.
   typedef struct packed {
      logic [IRQ_ID_W-1:0] id;
      logic [VEC_W-1:0]    vector;
   } irq_req_t;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-facing bus of the interrupt controller.
//   Register port : reg_addr, reg_wdata, reg_we (CPU drives), reg_rdata (controller drives)
//   Request port  : global_ie, irq_ack, irq_reti (CPU drives),
//                   irq_req, irq_id, irq_vector (controller drives)
interface irq_controller_if;
   import irq_controller_pkg::*;

   logic [ADDR_W-1:0]   reg_addr;
   logic [REG_W-1:0]    reg_wdata;
   logic                reg_we;
   logic [REG_W-1:0]    reg_rdata;
   logic                global_ie;
   logic                irq_req;
   logic [IRQ_ID_W-1:0] irq_id;
   logic [VEC_W-1:0]    irq_vector;
   logic                irq_ack;
   logic                irq_reti;

   modport master (
      output reg_addr, reg_wdata, reg_we, global_ie, irq_ack, irq_reti,
      input  reg_rdata, irq_req, irq_id, irq_vector
   );

   modport slave (
      input  reg_addr, reg_wdata, reg_we, global_ie, irq_ack, irq_reti,
      output reg_rdata, irq_req, irq_id, irq_vector
   );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
//   req : request vector, bit 0 has highest priority
//   any : at least one request bit set
//   idx : index of the lowest set bit (0 when none set)
module irq_prio_enc #(
   parameter int unsigned N     = 8,
   parameter int unsigned OUT_W = 3
) (
   input  logic [N-1:0]     req,
   output logic             any,
   output logic [OUT_W-1:0] idx
);

   assign any = |req;

   // Scan high to low so the lowest set index is written last.
   always_comb begin
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) idx = OUT_W'(i);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: NUM_IRQ channels with enable, edge/level mode,
// pending register, fixed priority (channel 0 highest) and in-service nesting.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : raw interrupt lines (same clock domain)
//   irq_clr    : one-cycle acknowledge pulse back to the source
//   bus        : register access and CPU request/ack/reti handshake
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int unsigned      NUM_IRQ      = 8,
   parameter logic [VEC_W-1:0] VECTOR_BASE  = 16'h0008,
   parameter int unsigned      VECTOR_SHIFT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [NUM_IRQ-1:0] irq_clr,
   irq_controller_if.slave    bus
);

   state_e               state_q, state_d;
   logic [NUM_IRQ-1:0]   enable_q, enable_d;
   logic [NUM_IRQ-1:0]   mode_q, mode_d;
   logic [NUM_IRQ-1:0]   pend_edge_q, pend_edge_d;
   logic [NUM_IRQ-1:0]   inservice_q, inservice_d;
   logic [NUM_IRQ-1:0]   prev_q, prev_d;
   logic [NUM_IRQ-1:0]   irq_clr_q, irq_clr_d;
   logic                 irq_req_q, irq_req_d;
   irq_req_t             cur_q, cur_d;

   logic [NUM_IRQ-1:0]   rise, pend_eff, prio_mask, elig, w1c;
   logic [NUM_IRQ-1:0]   ack_mask, reti_mask;
   logic [REG_W-1:0]     elig_ext;
   logic                 win_any, is_any, ack_ev;
   logic [IRQ_ID_W-1:0]  win_idx, is_idx;

   // Edge channels use the latched bit; level channels follow the live line.
   assign rise     = irq_in & ~prev_q & mode_q;
   assign pend_eff = (mode_q & pend_edge_q) | (~mode_q & irq_in);

   irq_prio_enc #(.N(NUM_IRQ), .OUT_W(IRQ_ID_W)) u_is_enc (
      .req (inservice_q),
      .any (is_any),
      .idx (is_idx)
   );

   // Only channels strictly above the highest in-service level may nest.
   always_comb begin
      prio_mask = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         prio_mask[i] = !is_any || (IRQ_ID_W'(i) < is_idx);
      end
   end

   assign elig     = pend_eff & enable_q & prio_mask;
   assign elig_ext = REG_W'(elig);

   irq_prio_enc #(.N(NUM_IRQ), .OUT_W(IRQ_ID_W)) u_win_enc (
      .req (elig),
      .any (win_any),
      .idx (win_idx)
   );

   assign ack_mask  = NUM_IRQ'(1) << cur_q.id;
   assign reti_mask = NUM_IRQ'(1) << is_idx;

   // State and register file.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         enable_q    <= '0;
         mode_q      <= '0;
         pend_edge_q <= '0;
         inservice_q <= '0;
         prev_q      <= '0;
         irq_clr_q   <= '0;
         irq_req_q   <= 1'b0;
         cur_q       <= '{id: '0, vector: VECTOR_BASE};
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         mode_q      <= mode_d;
         pend_edge_q <= pend_edge_d;
         inservice_q <= inservice_d;
         prev_q      <= prev_d;
         irq_clr_q   <= irq_clr_d;
         irq_req_q   <= irq_req_d;
         cur_q       <= cur_d;
      end
   end

   // Next-state: request FSM, register writes, pending and in-service update.
   always_comb begin
      state_d     = state_q;
      enable_d    = enable_q;
      mode_d      = mode_q;
      inservice_d = inservice_q;
      prev_d      = irq_in;
      irq_clr_d   = '0;
      irq_req_d   = irq_req_q;
      cur_d       = cur_q;
      w1c         = '0;
      ack_ev      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.global_ie && win_any) begin
               irq_req_d    = 1'b1;
               cur_d.id     = win_idx;
               cur_d.vector = VECTOR_BASE + VEC_W'(VEC_W'(win_idx) << VECTOR_SHIFT);
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack takes precedence over any withdraw condition.
            if (bus.irq_ack) begin
               ack_ev    = 1'b1;
               irq_clr_d = ack_mask;
               irq_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (!bus.global_ie || !elig_ext[cur_q.id]) begin
               irq_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.reg_we) begin
         case (reg_addr_e'(bus.reg_addr))
            REG_ENABLE:  enable_d = bus.reg_wdata[NUM_IRQ-1:0];
            REG_PENDING: w1c      = bus.reg_wdata[NUM_IRQ-1:0];
            REG_MODE:    mode_d   = bus.reg_wdata[NUM_IRQ-1:0];
            default:     ;
         endcase
      end

      // A new edge wins over W1C/ack clears; level channels hold no latched state.
      pend_edge_d = ((pend_edge_q & ~w1c & ~(ack_ev ? ack_mask : '0)) | rise) & mode_d;

      // Reti clears first, then ack sets.
      if (bus.irq_reti && is_any) inservice_d = inservice_d & ~reti_mask;
      if (ack_ev)                 inservice_d = inservice_d | ack_mask;
   end

   // Combinational register read; bits above NUM_IRQ read as zero.
   always_comb begin
      bus.reg_rdata = '0;
      case (reg_addr_e'(bus.reg_addr))
         REG_ENABLE:    bus.reg_rdata = REG_W'(enable_q);
         REG_PENDING:   bus.reg_rdata = REG_W'(pend_eff);
         REG_MODE:      bus.reg_rdata = REG_W'(mode_q);
         REG_INSERVICE: bus.reg_rdata = REG_W'(inservice_q);
         default:       bus.reg_rdata = '0;
      endcase
   end

   assign bus.irq_req    = irq_req_q;
   assign bus.irq_id     = cur_q.id;
   assign bus.irq_vector = cur_q.vector;
   assign irq_clr        = irq_clr_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller with hand-computed expectations.
module tb_irq_controller;
   import irq_controller_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic [7:0] irq_clr;
   int         n_pass;
   int         n_total;
   logic [7:0] rd;

   irq_controller_if bus_if();

   irq_controller #(
      .NUM_IRQ      (8),
      .VECTOR_BASE  (16'h0008),
      .VECTOR_SHIFT (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in),
      .irq_clr (irq_clr),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n cycles, landing 1 time unit after the posedge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      bus_if.reg_addr = a;
      #1;
      d = bus_if.reg_rdata;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      bus_if.reg_addr  = a;
      bus_if.reg_wdata = d;
      bus_if.reg_we    = 1'b1;
      cyc(1);
      bus_if.reg_we    = 1'b0;
   endtask

   task automatic pulse_edge(input logic [7:0] m);
      irq_in = irq_in | m;
      cyc(1);
      irq_in = irq_in & ~m;
   endtask

   task automatic do_ack();
      bus_if.irq_ack = 1'b1;
      cyc(1);
      bus_if.irq_ack = 1'b0;
   endtask

   task automatic do_reti();
      bus_if.irq_reti = 1'b1;
      cyc(1);
      bus_if.irq_reti = 1'b0;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      irq_in           = '0;
      bus_if.reg_we    = 1'b0;
      bus_if.irq_ack   = 1'b0;
      bus_if.irq_reti  = 1'b0;
      bus_if.global_ie = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL reset_req got %0h want 0", bus_if.irq_req); else n_pass++;
      n_total++; if (bus_if.irq_id !== 3'd0) $display("FAIL reset_id got %0h want 0", bus_if.irq_id); else n_pass++;
      n_total++; if (bus_if.irq_vector !== 16'h0008) $display("FAIL reset_vec got %h want 0008", bus_if.irq_vector); else n_pass++;
      n_total++; if (irq_clr !== 8'h00) $display("FAIL reset_clr got %h want 00", irq_clr); else n_pass++;
      for (int a = 0; a < 4; a++) begin
         rd_reg(2'(a), rd);
         n_total++; if (rd !== 8'h00) $display("FAIL reset_reg%0d got %h want 00", a, rd); else n_pass++;
      end
   endtask

   task automatic test_basic_edge();
      do_reset();
      wr_reg(2'd0, 8'h01);
      wr_reg(2'd2, 8'h01);
      pulse_edge(8'h01);
      rd_reg(2'd1, rd);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL basic_req_n1 got %0h want 0", bus_if.irq_req); else n_pass++;
      n_total++; if (rd !== 8'h01) $display("FAIL basic_pend_n1 got %h want 01", rd); else n_pass++;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1) $display("FAIL basic_req_n2 got %0h want 1", bus_if.irq_req); else n_pass++;
      n_total++; if (bus_if.irq_vector !== 16'h0008) $display("FAIL basic_vec got %h want 0008", bus_if.irq_vector); else n_pass++;
      do_ack();
      n_total++; if (irq_clr !== 8'h01) $display("FAIL basic_clr got %h want 01", irq_clr); else n_pass++;
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL basic_req_ack got %0h want 0", bus_if.irq_req); else n_pass++;
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h01) $display("FAIL basic_insvc got %h want 01", rd); else n_pass++;
      rd_reg(2'd1, rd);
      n_total++; if (rd !== 8'h00) $display("FAIL basic_pend_ack got %h want 00", rd); else n_pass++;
      wr_reg(2'd3, 8'hFF);
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h01) $display("FAIL basic_insvc_ro got %h want 01", rd); else n_pass++;
      n_total++; if (irq_clr !== 8'h00) $display("FAIL basic_clr_once got %h want 00", irq_clr); else n_pass++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      wr_reg(2'd0, 8'h24);
      wr_reg(2'd2, 8'h24);
      pulse_edge(8'h24);
      cyc(1);
      n_total++; if (bus_if.irq_id !== 3'd2) $display("FAIL same_id got %0d want 2", bus_if.irq_id); else n_pass++;
      n_total++; if (bus_if.irq_vector !== 16'h000C) $display("FAIL same_vec got %h want 000C", bus_if.irq_vector); else n_pass++;
      do_ack();
      n_total++; if (irq_clr !== 8'h04) $display("FAIL same_clr got %h want 04", irq_clr); else n_pass++;
      cyc(2);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL same_blocked got %0h want 0", bus_if.irq_req); else n_pass++;
      do_reti();
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1) $display("FAIL same_req5 got %0h want 1", bus_if.irq_req); else n_pass++;
      n_total++; if (bus_if.irq_id !== 3'd5) $display("FAIL same_id5 got %0d want 5", bus_if.irq_id); else n_pass++;
      n_total++; if (bus_if.irq_vector !== 16'h0012) $display("FAIL same_vec5 got %h want 0012", bus_if.irq_vector); else n_pass++;
   endtask

   task automatic test_nesting();
      do_reset();
      wr_reg(2'd0, 8'h4A);
      wr_reg(2'd2, 8'h4A);
      pulse_edge(8'h08);
      cyc(1);
      do_ack();
      pulse_edge(8'h02);
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1 || bus_if.irq_id !== 3'd1)
         $display("FAIL nest_req1 got req=%0h id=%0d want req=1 id=1", bus_if.irq_req, bus_if.irq_id); else n_pass++;
      do_ack();
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h0A) $display("FAIL nest_insvc got %h want 0A", rd); else n_pass++;
      do_reti();
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h08) $display("FAIL nest_reti1 got %h want 08", rd); else n_pass++;
      pulse_edge(8'h40);
      cyc(3);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL nest_ch6_blocked got %0h want 0", bus_if.irq_req); else n_pass++;
      do_reti();
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1 || bus_if.irq_id !== 3'd6)
         $display("FAIL nest_req6 got req=%0h id=%0d want req=1 id=6", bus_if.irq_req, bus_if.irq_id); else n_pass++;
      n_total++; if (bus_if.irq_vector !== 16'h0014) $display("FAIL nest_vec6 got %h want 0014", bus_if.irq_vector); else n_pass++;
   endtask

   task automatic test_level();
      do_reset();
      wr_reg(2'd0, 8'h10);
      irq_in = 8'h10;
      rd_reg(2'd1, rd);
      n_total++; if (rd !== 8'h10) $display("FAIL lvl_pend_live got %h want 10", rd); else n_pass++;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1 || bus_if.irq_vector !== 16'h0010)
         $display("FAIL lvl_req got req=%0h vec=%h want req=1 vec=0010", bus_if.irq_req, bus_if.irq_vector); else n_pass++;
      do_ack();
      n_total++; if (irq_clr !== 8'h10) $display("FAIL lvl_clr got %h want 10", irq_clr); else n_pass++;
      wr_reg(2'd1, 8'h10);
      rd_reg(2'd1, rd);
      n_total++; if (rd !== 8'h10) $display("FAIL lvl_w1c_noeffect got %h want 10", rd); else n_pass++;
      cyc(3);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL lvl_no_rereq got %0h want 0", bus_if.irq_req); else n_pass++;
      do_reti();
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1 || bus_if.irq_id !== 3'd4)
         $display("FAIL lvl_rereq got req=%0h id=%0d want req=1 id=4", bus_if.irq_req, bus_if.irq_id); else n_pass++;
      irq_in = '0;
   endtask

   task automatic test_w1c();
      do_reset();
      wr_reg(2'd0, 8'h01);
      wr_reg(2'd2, 8'h01);
      pulse_edge(8'h01);
      cyc(1);
      wr_reg(2'd1, 8'h01);
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b0 || irq_clr !== 8'h00)
         $display("FAIL w1c_withdraw got req=%0h clr=%h want req=0 clr=00", bus_if.irq_req, irq_clr); else n_pass++;
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h00) $display("FAIL w1c_insvc got %h want 00", rd); else n_pass++;
      pulse_edge(8'h01);
      cyc(1);
      bus_if.reg_addr  = 2'd1;
      bus_if.reg_wdata = 8'h01;
      bus_if.reg_we    = 1'b1;
      bus_if.irq_ack   = 1'b1;
      cyc(1);
      bus_if.reg_we    = 1'b0;
      bus_if.irq_ack   = 1'b0;
      n_total++; if (irq_clr !== 8'h01 || bus_if.irq_req !== 1'b0)
         $display("FAIL w1c_ackwins got clr=%h req=%0h want clr=01 req=0", irq_clr, bus_if.irq_req); else n_pass++;
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h01) $display("FAIL w1c_ack_insvc got %h want 01", rd); else n_pass++;
   endtask

   task automatic test_gie_and_reset();
      do_reset();
      bus_if.global_ie = 1'b0;
      wr_reg(2'd0, 8'h01);
      wr_reg(2'd2, 8'h01);
      pulse_edge(8'h01);
      do_ack();
      cyc(2);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL gie_off_req got %0h want 0", bus_if.irq_req); else n_pass++;
      rd_reg(2'd3, rd);
      n_total++; if (rd !== 8'h00) $display("FAIL gie_idle_ack got %h want 00", rd); else n_pass++;
      bus_if.global_ie = 1'b1;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1) $display("FAIL gie_on_req got %0h want 1", bus_if.irq_req); else n_pass++;
      bus_if.global_ie = 1'b0;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b0) $display("FAIL gie_withdraw got %0h want 0", bus_if.irq_req); else n_pass++;
      bus_if.global_ie = 1'b1;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b1) $display("FAIL gie_rereq got %0h want 1", bus_if.irq_req); else n_pass++;
      reset = 1'b1;
      cyc(1);
      n_total++; if (bus_if.irq_req !== 1'b0 || bus_if.irq_id !== 3'd0 || bus_if.irq_vector !== 16'h0008 || irq_clr !== 8'h00)
         $display("FAIL midreq_reset got req=%0h id=%0d vec=%h clr=%h want 0 0 0008 00",
                  bus_if.irq_req, bus_if.irq_id, bus_if.irq_vector, irq_clr); else n_pass++;
      rd_reg(2'd0, rd);
      n_total++; if (rd !== 8'h00) $display("FAIL midreq_enable got %h want 00", rd); else n_pass++;
      rd_reg(2'd1, rd);
      n_total++; if (rd !== 8'h00) $display("FAIL midreq_pend got %h want 00", rd); else n_pass++;
      reset = 1'b0;
   endtask

   initial begin
      n_pass           = 0;
      n_total          = 0;
      reset            = 1'b1;
      irq_in           = '0;
      bus_if.reg_addr  = '0;
      bus_if.reg_wdata = '0;
      bus_if.reg_we    = 1'b0;
      bus_if.global_ie = 1'b1;
      bus_if.irq_ack   = 1'b0;
      bus_if.irq_reti  = 1'b0;
      test_reset();
      test_basic_edge();
      test_same_cycle();
      test_nesting();
      test_level();
      test_w1c();
      test_gie_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
